// File: rtl/div_pkg.sv
// div_pkg: shared constants and state encoding for the multi-cycle divider.
package div_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'b00;
  localparam state_t BUSY = 2'b01;
  localparam state_t DONE = 2'b10;

endpackage

// File: rtl/div_if.sv
// div_if: request/response bundle between the execute stage (master) and the divider (slave).
interface div_if
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic               en;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               sign;
  logic               interrupt;
  logic               busy;
  logic               data_ok;
  logic [2*WIDTH-1:0] result;

  modport master (
    output en, a, b, sign, interrupt,
    input  busy, data_ok, result
  );

  modport slave (
    input  en, a, b, sign, interrupt,
    output busy, data_ok, result
  );

endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step; chain two of these for 2 bits/cycle.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted_s;

  // Shift in the next dividend bit; keep the carry bit so unsigned divisors above 2^(W-1) compare correctly.
  always_comb begin
    shifted_s = {rem_i, msb_i};
    if (shifted_s >= {1'b0, divisor_i}) begin
      rem_o = shifted_s[WIDTH-1:0] - divisor_i;
      q_o   = 1'b1;
    end else begin
      rem_o = shifted_s[WIDTH-1:0];
      q_o   = 1'b0;
    end
  end

endmodule

// File: rtl/div.sv
// div: multi-cycle radix-2 restoring divider for DIV/DIVU; result = {HI=remainder, LO=quotient}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes in DONE the cycle after accept.
module div
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic   clk,
  input logic   rst,
  div_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   abs_b_q, abs_b_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               b_zero_q, b_zero_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               accept_s;
  logic               in_sign_a_s, in_sign_b_s, in_b_zero_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s;
  logic [WIDTH-1:0]   step_rem_s, quo_raw_s, quo_fix_s, rem_fix_s;
  logic               step_q_s;
  logic               busy_s, data_ok_s;

  // Operand conditioning at accept: signs and magnitudes.
  always_comb begin
    accept_s    = bus.en & ~bus.interrupt;
    in_sign_a_s = bus.sign & bus.a[WIDTH-1];
    in_sign_b_s = bus.sign & bus.b[WIDTH-1];
    abs_a_s     = in_sign_a_s ? (~bus.a + ONE) : bus.a;
    abs_b_s     = in_sign_b_s ? (~bus.b + ONE) : bus.b;
    in_b_zero_s = (bus.b == ZERO);
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .msb_i     (dvd_q[WIDTH-1]),
    .divisor_i (abs_b_q),
    .rem_o     (step_rem_s),
    .q_o       (step_q_s)
  );

  // Final-step sign fix-up; a zero divisor forces an all-ones quotient and leaves the remainder equal to a.
  always_comb begin
    quo_raw_s = {dvd_q[WIDTH-2:0], step_q_s};
    quo_fix_s = b_zero_q ? ONES : ((sign_a_q ^ sign_b_q) ? (~quo_raw_s + ONE) : quo_raw_s);
    rem_fix_s = sign_a_q ? (~step_rem_s + ONE) : step_rem_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
`ifdef DIV_ZERO_FAST_EN
          state_d = in_b_zero_s ? DONE : BUSY;
`else
          state_d = BUSY;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (bus.interrupt) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch at accept, one restoring step per BUSY cycle, load result on the last step.
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    abs_b_d  = abs_b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          sign_a_d = in_sign_a_s;
          sign_b_d = in_sign_b_s;
          dvd_d    = abs_a_s;
          abs_b_d  = abs_b_s;
          b_zero_d = in_b_zero_s;
          rem_d    = ZERO;
          cnt_d    = {CNT_W{1'b0}};
`ifdef DIV_ZERO_FAST_EN
          if (in_b_zero_s) begin
            result_d = {bus.a, ONES};
          end else begin
            result_d = result_q;
          end
`endif
        end else begin
          cnt_d = cnt_q;
        end
      end
      BUSY: begin
        if (!bus.interrupt) begin
          rem_d = step_rem_s;
          dvd_d = quo_raw_s;
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == LAST_CNT) begin
            result_d = {rem_fix_s, quo_fix_s};
          end else begin
            result_d = result_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      DONE:    cnt_d = cnt_q;
      default: cnt_d = cnt_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= {CNT_W{1'b0}};
      rem_q    <= ZERO;
      dvd_q    <= ZERO;
      abs_b_q  <= ZERO;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      result_q <= {(2*WIDTH){1'b0}};
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      abs_b_q  <= abs_b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      result_q <= result_d;
    end
  end

  // Status outputs decoded from state.
  always_comb begin
    busy_s    = (state_q != IDLE);
    data_ok_s = (state_q == DONE);
  end

  assign bus.busy    = busy_s;
  assign bus.data_ok = data_ok_s;
  assign bus.result  = result_q;

endmodule
